// File: rtl/b_dly_ctrl.sv
// Closed-loop delay-select controller: majority-votes the phase detector and steps the code +/-1.
// Optional manual override port pair guarded by `B_DLY_CTRL_OVRD_EN.
module b_dly_ctrl #(
  parameter int         SETTLE_CYC   = 4,
  parameter int         VOTE_LEN     = 8,
  parameter int         LOCK_TOGGLES = 4,
  parameter logic [7:0] INIT_SEL     = 8'd128
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_en,
  input  logic       i_cal_start,
  input  logic       i_pd_lead,
`ifdef B_DLY_CTRL_OVRD_EN
  input  logic       i_ovrd_en,
  input  logic [7:0] i_ovrd_sel,
`endif
  output logic [7:0] o_dly_sel,
  output logic       o_busy,
  output logic       o_lock,
  output logic       o_sat
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_UPDATE} state_t;
  typedef enum logic [1:0] {D_NONE, D_UP, D_DN} dir_t;

  state_t     state_q, state_d;
  dir_t       last_q, last_d, vote;
  logic [6:0] cnt_q, cnt_d, lead_q, lead_d;
  logic [7:0] code_q, code_d;
  logic [3:0] tog_q, tog_d;
  logic       lock_q, lock_d, sat_q, sat_d, rep_q, rep_d;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      last_q  <= D_NONE;
      cnt_q   <= '0;
      lead_q  <= '0;
      code_q  <= INIT_SEL;
      tog_q   <= '0;
      lock_q  <= 1'b0;
      sat_q   <= 1'b0;
      rep_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      lead_q  <= lead_d;
      code_q  <= code_d;
      tog_q   <= tog_d;
      lock_q  <= lock_d;
      sat_q   <= sat_d;
      rep_q   <= rep_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    lead_d  = lead_q;
    code_d  = code_q;
    tog_d   = tog_q;
    lock_d  = lock_q;
    sat_d   = sat_q;
    rep_d   = rep_q;

    vote = D_NONE;
    if (lead_q > 7'(VOTE_LEN / 2))      vote = D_UP;
    else if (lead_q < 7'(VOTE_LEN / 2)) vote = D_DN;

    case (state_q)
      S_IDLE: begin
        if (i_en && i_cal_start) begin
          code_d  = INIT_SEL;
          lock_d  = 1'b0;
          tog_d   = '0;
          last_d  = D_NONE;
          rep_d   = 1'b0;
          cnt_d   = '0;
          lead_d  = '0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == 7'(SETTLE_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      S_SAMPLE: begin
        lead_d = lead_q + {6'd0, i_pd_lead};
        if (cnt_q == 7'(VOTE_LEN - 1)) begin
          cnt_d   = '0;
          state_d = S_UPDATE;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      S_UPDATE: begin
        cnt_d   = '0;
        lead_d  = '0;
        state_d = S_SETTLE;
        if (vote == D_NONE) begin
          sat_d = 1'b0;
        end else begin
          sat_d = (vote == D_UP && code_q == 8'd255) || (vote == D_DN && code_q == 8'd0);
          if (vote == D_UP && code_q != 8'd255) code_d = code_q + 8'd1;
          if (vote == D_DN && code_q != 8'd0)   code_d = code_q - 8'd1;
          // rep tracks a repeat of the previous non-HOLD vote; a second repeat drops lock
          if (last_q == D_NONE) begin
            tog_d = '0;
            rep_d = 1'b0;
          end else if (vote == last_q) begin
            tog_d = '0;
            if (rep_q && lock_q) lock_d = 1'b0;
            rep_d = 1'b1;
          end else begin
            if (tog_q != 4'd15) tog_d = tog_q + 4'd1;
            rep_d = 1'b0;
            if (tog_d == 4'(LOCK_TOGGLES)) lock_d = 1'b1;
          end
          last_d = vote;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // disable aborts the loop but lets an in-flight UPDATE land
    if (!i_en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      lead_d  = '0;
    end

`ifdef B_DLY_CTRL_OVRD_EN
    if (i_ovrd_en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      lead_d  = '0;
      lock_d  = 1'b0;
      sat_d   = 1'b0;
      code_d  = i_ovrd_sel;
    end
`endif
  end

  assign o_dly_sel = code_q;
  assign o_busy    = (state_q != S_IDLE);
  assign o_lock    = lock_q;
  assign o_sat     = sat_q;

endmodule

// File: tb/tb_b_dly_ctrl.sv
// Directed bench for b_dly_ctrl: start, climb, lock/lock-loss, tie, saturation, disable (+override).
module tb_b_dly_ctrl;
  logic       clk = 1'b0;
  logic       rstn, en, cal, pd;
  logic [7:0] dly;
  logic       busy, lock, sat;
`ifdef B_DLY_CTRL_OVRD_EN
  logic       ovrd_en = 1'b0;
  logic [7:0] ovrd_sel = 8'h00;
`endif
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  b_dly_ctrl dut (
    .i_clk(clk), .i_rstn(rstn), .i_en(en), .i_cal_start(cal), .i_pd_lead(pd),
`ifdef B_DLY_CTRL_OVRD_EN
    .i_ovrd_en(ovrd_en), .i_ovrd_sel(ovrd_sel),
`endif
    .o_dly_sel(dly), .o_busy(busy), .o_lock(lock), .o_sat(sat)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // one full step period from SETTLE entry: 4 settle, 8 samples (first 'ones' are 1), 1 update
  task automatic window(input int ones);
    for (int i = 0; i < 13; i++) begin
      pd = (i >= 4 && (i - 4) < ones);
      tick();
    end
    pd = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; en = 1'b0; cal = 1'b0; pd = 1'b0;
    repeat (3) tick();
    tests++; if (dly !== 8'd128 || busy !== 1'b0 || lock !== 1'b0 || sat !== 1'b0) begin
      fails++; $display("FAIL reset dly=%0d busy=%b lock=%b sat=%b exp 128/0/0/0", dly, busy, lock, sat); end
    rstn = 1'b1; en = 1'b1; cal = 1'b1;
    tick(); cal = 1'b0;
    tests++; if (dly !== 8'd128 || busy !== 1'b1) begin
      fails++; $display("FAIL start dly=%0d busy=%b exp 128/1", dly, busy); end
    pd = 1'b1;
    repeat (12) tick();
    tests++; if (dly !== 8'd128) begin
      fails++; $display("FAIL early_change dly=%0d exp 128", dly); end
    tick(); pd = 1'b0;
    tests++; if (dly !== 8'd129) begin
      fails++; $display("FAIL first_step dly=%0d exp 129", dly); end
  endtask

  task automatic test_climb();
    repeat (9) window(8);
    tests++; if (dly !== 8'd138 || lock !== 1'b0 || sat !== 1'b0) begin
      fails++; $display("FAIL climb dly=%0d lock=%b sat=%b exp 138/0/0", dly, lock, sat); end
  endtask

  task automatic test_lock();
    en = 1'b0; tick();
    en = 1'b1; cal = 1'b1; tick(); cal = 1'b0;
    tests++; if (dly !== 8'd128) begin
      fails++; $display("FAIL restart dly=%0d exp 128", dly); end
    window(8); window(0); window(8); window(0);
    tests++; if (dly !== 8'd128 || lock !== 1'b0) begin
      fails++; $display("FAIL pre_lock dly=%0d lock=%b exp 128/0", dly, lock); end
    window(8);
    tests++; if (dly !== 8'd129 || lock !== 1'b1) begin
      fails++; $display("FAIL lock dly=%0d lock=%b exp 129/1", dly, lock); end
  endtask

  task automatic test_tie_lockloss();
    window(4);
    tests++; if (dly !== 8'd129 || lock !== 1'b1) begin
      fails++; $display("FAIL tie dly=%0d lock=%b exp 129/1", dly, lock); end
    window(5);
    tests++; if (dly !== 8'd130 || lock !== 1'b1) begin
      fails++; $display("FAIL up_once dly=%0d lock=%b exp 130/1", dly, lock); end
    // also checks i_cal_start is ignored outside IDLE
    cal = 1'b1; tick(); cal = 1'b0;
    for (int i = 1; i < 13; i++) begin pd = (i >= 4); tick(); end
    pd = 1'b0;
    tests++; if (dly !== 8'd131 || lock !== 1'b0) begin
      fails++; $display("FAIL lock_loss dly=%0d lock=%b exp 131/0", dly, lock); end
    window(3);
    tests++; if (dly !== 8'd130 || lock !== 1'b0) begin
      fails++; $display("FAIL down3 dly=%0d lock=%b exp 130/0", dly, lock); end
  endtask

  task automatic test_saturation();
    repeat (124) window(8);
    tests++; if (dly !== 8'd254 || sat !== 1'b0) begin
      fails++; $display("FAIL at254 dly=%0d sat=%b exp 254/0", dly, sat); end
    window(8);
    tests++; if (dly !== 8'd255 || sat !== 1'b0) begin
      fails++; $display("FAIL to255 dly=%0d sat=%b exp 255/0", dly, sat); end
    window(8);
    tests++; if (dly !== 8'd255 || sat !== 1'b1) begin
      fails++; $display("FAIL sat dly=%0d sat=%b exp 255/1", dly, sat); end
    window(0);
    tests++; if (dly !== 8'd254 || sat !== 1'b0) begin
      fails++; $display("FAIL unsat dly=%0d sat=%b exp 254/0", dly, sat); end
  endtask

  task automatic test_disable();
    pd = 1'b1;
    repeat (6) tick();
    en = 1'b0; tick();
    tests++; if (busy !== 1'b0 || dly !== 8'd254) begin
      fails++; $display("FAIL dis_sample busy=%b dly=%0d exp 0/254", busy, dly); end
    repeat (20) tick();
    tests++; if (busy !== 1'b0 || dly !== 8'd254) begin
      fails++; $display("FAIL dis_hold busy=%b dly=%0d exp 0/254", busy, dly); end
    en = 1'b1; cal = 1'b1; tick(); cal = 1'b0;
    repeat (12) tick();
    en = 1'b0; tick(); pd = 1'b0;
    tests++; if (busy !== 1'b0 || dly !== 8'd129) begin
      fails++; $display("FAIL dis_update busy=%b dly=%0d exp 0/129", busy, dly); end
  endtask

`ifdef B_DLY_CTRL_OVRD_EN
  task automatic test_ovrd();
    en = 1'b1; ovrd_en = 1'b1; ovrd_sel = 8'h40; tick();
    tests++; if (dly !== 8'h40 || busy !== 1'b0 || lock !== 1'b0) begin
      fails++; $display("FAIL ovrd dly=%0h busy=%b lock=%b exp 40/0/0", dly, busy, lock); end
    ovrd_en = 1'b0; cal = 1'b1; tick(); cal = 1'b0;
    tests++; if (dly !== 8'd128 || busy !== 1'b1) begin
      fails++; $display("FAIL ovrd_release dly=%0d busy=%b exp 128/1", dly, busy); end
  endtask
`endif

  initial begin
    test_reset();
    test_climb();
    test_lock();
    test_tie_lockloss();
    test_saturation();
    test_disable();
`ifdef B_DLY_CTRL_OVRD_EN
    test_ovrd();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/b_dly_ctrl.md
Name: b_dly_ctrl

Overview:
- Closed-loop controller that produces the 8-bit delay-select code for the downstream delay line (b_dly_line).
- Samples a phase-detector decision bit, majority-votes it over a window, and steps the code up or down by 1.
- Declares lock after repeated direction reversals, then keeps tracking.
- Sits between the phase detector and the delay line; its o_dly_sel drives i_dly_sel directly.

Parameters:
- SETTLE_CYC, 4: cycles waited after any code change before sampling starts (1..15).
- VOTE_LEN, 8: phase-detector samples per vote window (even, 2..64).
- LOCK_TOGGLES, 4: consecutive direction reversals required to assert lock (1..15).
- INIT_SEL, 8'd128: code loaded at reset and on calibration start.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rstn  input  1  synchronous reset, active-low.
- i_en  input  1  controller enable; low forces IDLE and holds the code.
- i_cal_start  input  1  single-cycle pulse; starts calibration from IDLE.
- i_pd_lead  input  1  phase-detector bit, already synchronised. 1 = delayed edge leads reference (needs more delay); 0 = lags.
- o_dly_sel  output  8  delay-select code to the delay line.
- o_busy  output  1  high in any state other than IDLE.
- o_lock  output  1  lock indication.
- o_sat  output  1  high while the code is clamped at 0 or 255 and the last vote pointed beyond the limit.

Behaviour:
- Reset (i_rstn=0 at a clock edge):
  - o_dly_sel=INIT_SEL; o_busy=0; o_lock=0; o_sat=0.
  - State IDLE; all counters 0; the last-direction register is cleared to NONE.
- States: IDLE, SETTLE, SAMPLE, UPDATE.
- IDLE:
  - o_busy=0; code held.
  - On i_en=1 && i_cal_start=1: load INIT_SEL, clear lock, toggle count and last direction, then go to SETTLE.
  - i_cal_start outside IDLE is ignored.
- SETTLE: counts SETTLE_CYC cycles, then goes to SAMPLE.
- SAMPLE:
  - Samples i_pd_lead on each of VOTE_LEN cycles and counts the 1s (lead_cnt), then goes to UPDATE.
- UPDATE (1 cycle). Vote result:
  - UP if lead_cnt > VOTE_LEN/2.
  - DN if lead_cnt < VOTE_LEN/2.
  - HOLD if lead_cnt = VOTE_LEN/2.
- Code update:
  - UP: code+1, saturating at 255.
  - DN: code-1, saturating at 0.
  - HOLD: unchanged.
  - The new code is visible on o_dly_sel the cycle after UPDATE.
  - One step period is SETTLE_CYC+VOTE_LEN+1 cycles (13 at defaults).
- Saturation:
  - o_sat is set in UPDATE when the vote is UP with code=255, or DN with code=0.
  - o_sat is cleared by any other vote.
  - A clamped vote still updates the last direction.
- Lock logic, evaluated in UPDATE:
  - Vote opposite to last direction: toggle count +1, saturating at 15.
  - Same as last direction: toggle count = 0.
  - HOLD: toggle count and last direction unchanged.
  - A non-HOLD vote updates the last direction.
  - o_lock is set when the toggle count reaches LOCK_TOGGLES.
- Lock loss:
  - While locked, two consecutive identical non-HOLD votes clear o_lock; tracking continues.
- After UPDATE the FSM always returns to SETTLE; tracking is continuous while i_en=1.
- i_en=0 in any state:
  - Next cycle the FSM is in IDLE, counters are cleared, and o_busy=0.
  - o_dly_sel and o_lock are held.
  - If i_en deasserts in UPDATE, the update of that same cycle still completes.
- Reset mid-operation: identical to power-on reset; no partial update is applied.
- o_dly_sel is registered; it changes only in the cycle after UPDATE, never mid-window.

Optional Feature:
- Macro: B_DLY_CTRL_OVRD_EN.
- When defined, adds ports:
  - i_ovrd_en  input  1: override enable.
  - i_ovrd_sel  input  8: override code.
- With i_ovrd_en=1:
  - o_dly_sel=i_ovrd_sel (registered, 1-cycle latency).
  - The FSM is forced to IDLE; o_lock=0; o_sat=0.
  - The internal code register is loaded with i_ovrd_sel, so tracking resumes from the override value after the next i_cal_start.
- When undefined: the ports are absent and behaviour is exactly as above.

Test Plan:
- Reset/start: i_rstn low 3 cycles, then i_en=1 and a 1-cycle i_cal_start pulse → o_dly_sel=128, o_busy=1 the next cycle, first code change 13 cycles later.
- Monotonic climb: i_pd_lead=1 constantly for 10 steps → o_dly_sel=138, o_lock=0, o_sat=0.
- Lock: i_pd_lead alternating per window (all-1 window, then all-0 window, ...) → code toggles 129/128; o_lock rises in the UPDATE of the 5th vote (4th reversal).
- Tie and saturation:
  - 4 of 8 samples =1 → code unchanged, toggle count unchanged.
  - Start at 254 with constant lead → code 255, then o_sat=1 with code staying at 255.
- Lock loss and disable:
  - After lock, two UP votes → o_lock drops after the second UPDATE.
  - i_en=0 mid-SAMPLE → IDLE the next cycle, code held.
- Override (macro defined): i_ovrd_en=1, i_ovrd_sel=8'h40 → o_dly_sel=8'h40 one cycle later, o_busy=0.
  - Release i_ovrd_en and pulse i_cal_start → code restarts at INIT_SEL=128.
